// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler sharing one sequential signed multiplier among NREQ requesters
//   clk, rst               : clock, async active-high reset
//   req_valid/ready/a/b    : per-requester operand handshake, operands packed i*WIDTH
//   rsp_valid/ready/id/data: tagged signed product return
//   busy                   : high whenever not IDLE
//   mult_rst/en/a/b/out    : sequencing of the shared multiplier
module mult_share_sched #(
  parameter int WIDTH = 32,
  parameter int NREQ = 4,
  parameter int MULT_LATENCY = 34,
  localparam int ID_W = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [2*WIDTH-1:0]    rsp_data,
  output logic                  busy,
  output logic                  mult_rst,
  output logic                  mult_en,
  output logic [WIDTH-1:0]      mult_a,
  output logic [WIDTH-1:0]      mult_b,
  input  logic [2*WIDTH-1:0]    mult_out
);
  localparam int CNT_W = MULT_LATENCY > 1 ? $clog2(MULT_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t state;
  logic [ID_W-1:0] ptr, win;
  logic [CNT_W-1:0] cnt;
  logic found;
  // requester j sits at offset i from ptr when ptr == (j-i) mod NREQ; the
  // descending offset scan leaves the closest valid requester as winner
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      for (int j = 0; j < NREQ; j++)
        if (int'(ptr) == (j - i + NREQ) % NREQ && req_valid[j]) begin
          win = ID_W'(j);
          found = 1'b1;
        end
  end
  assign req_ready = (state == IDLE && found) ? NREQ'(1) << win : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      mult_rst <= 1'b1;
      mult_en <= 1'b0;
      mult_a <= '0;
      mult_b <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      busy <= 1'b0;
    end else
      case (state)
        IDLE:
          if (found) begin
            mult_a <= req_a[win*WIDTH +: WIDTH];
            mult_b <= req_b[win*WIDTH +: WIDTH];
            rsp_id <= win;
            ptr <= ID_W'((int'(win) + 1) % NREQ);
            busy <= 1'b1;
            state <= LOAD;
          end
        LOAD: begin
          cnt <= '0;
          mult_rst <= 1'b0;
          mult_en <= 1'b1;
          state <= RUN;
        end
        RUN:
          if (cnt == CNT_W'(MULT_LATENCY - 1)) begin
            rsp_data <= mult_out;
            rsp_valid <= 1'b1;
            mult_rst <= 1'b1;
            mult_en <= 1'b0;
            state <= RESP;
          end else
            cnt <= cnt + CNT_W'(1);
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy <= 1'b0;
            state <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_mult_share_sched.sv
// tb_mult_share_sched: directed self-checking bench for mult_share_sched with a latency-accurate multiplier model
module tb_mult_share_sched;
  localparam int W = 32;
  localparam int N = 4;
  localparam int LAT = 34;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [1:0] rsp_id;
  logic [2*W-1:0] rsp_data;
  logic busy, mult_rst, mult_en;
  logic [W-1:0] mult_a, mult_b;
  logic [2*W-1:0] mult_out;
  logic signed [2*W-1:0] pa, pb;
  int mcnt = 0;
  int checks = 0;
  int failures = 0;
  mult_share_sched #(.WIDTH(W), .NREQ(N), .MULT_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy), .mult_rst(mult_rst),
    .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b), .mult_out(mult_out)
  );
  always #5 clk = ~clk;
  // multiplier model: product valid only once en has been high for LAT cycles since rst dropped
  always @(posedge clk)
    if (mult_rst) mcnt <= 0;
    else if (mult_en) mcnt <= mcnt + 1;
  assign pa = $signed(mult_a);
  assign pb = $signed(mult_b);
  assign mult_out = (!mult_rst && mcnt >= LAT - 1) ? pa * pb : 64'hDEAD_BEEF_DEAD_BEEF;
  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic set_op(input int i, input int a, input int b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask
  task automatic wait_grant(output logic [N-1:0] g, output int n);
    #1;
    n = 0;
    while (req_ready == '0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    g = req_ready;
  endtask
  task automatic wait_rsp(input int start, output int n);
    n = start;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic test_reset();
    req_valid = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({mult_rst, mult_en} !== 2'b10) begin failures++; $display("FAIL reset_mult_ctl got=%b exp=10", {mult_rst, mult_en}); end
    checks++; if ({mult_a, mult_b} !== '0) begin failures++; $display("FAIL reset_operands got=%h exp=0", {mult_a, mult_b}); end
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== '0) begin failures++; $display("FAIL reset_rsp got=%b %h %h exp=0", rsp_valid, rsp_id, rsp_data); end
    checks++; if ({busy, req_ready} !== '0) begin failures++; $display("FAIL reset_busy_ready got=%b %b exp=0 0000", busy, req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic test_single();
    int n;
    do_reset();
    set_op(0, 12, -32);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if ({mult_a, mult_b} !== {32'd12, 32'hFFFF_FFE0}) begin failures++; $display("FAIL single_latch got=%h %h exp=0000000c ffffffe0", mult_a, mult_b); end
    checks++; if ({busy, mult_rst, mult_en} !== 3'b110) begin failures++; $display("FAIL single_load_ctl got=%b exp=110", {busy, mult_rst, mult_en}); end
    @(posedge clk); #1;
    checks++; if ({mult_rst, mult_en} !== 2'b01) begin failures++; $display("FAIL single_run_ctl got=%b exp=01", {mult_rst, mult_en}); end
    wait_rsp(2, n);
    checks++; if (n !== 36) begin failures++; $display("FAIL single_latency got=%0d exp=36", n); end
    checks++; if (rsp_id !== 2'd0 || rsp_data !== -64'sd384) begin failures++; $display("FAIL single_rsp got=%0d %h exp=0 %h", rsp_id, rsp_data, -64'sd384); end
    checks++; if ({mult_rst, mult_en} !== 2'b10) begin failures++; $display("FAIL single_resp_ctl got=%b exp=10", {mult_rst, mult_en}); end
    @(posedge clk); #1;
    checks++; if ({rsp_valid, busy} !== 2'b00) begin failures++; $display("FAIL single_resp_1cycle got=%b exp=00", {rsp_valid, busy}); end
  endtask
  task automatic test_all_four();
    logic [N-1:0] g;
    logic [2*W-1:0] exp_d [4];
    int n, gn;
    exp_d = '{64'd75, 64'd204, 64'd1500, 64'd0};
    do_reset();
    set_op(0, 5, 15);
    set_op(1, -51, -4);
    set_op(2, -25, -60);
    set_op(3, 0, 1234);
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, gn);
      checks++; if (g !== 4'(1 << k)) begin failures++; $display("FAIL all4_grant%0d got=%b exp=%b", k, g, 4'(1 << k)); end
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      wait_rsp(1, n);
      checks++; if (n !== 36 || rsp_id !== 2'(k) || rsp_data !== exp_d[k]) begin failures++; $display("FAIL all4_rsp%0d got=%0d %0d %h exp=36 %0d %h", k, n, rsp_id, rsp_data, k, exp_d[k]); end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back();
    logic [N-1:0] g;
    int n, gn;
    do_reset();
    set_op(0, 13, 20);
    set_op(2, 13, 20);
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, gn);
      checks++; if (g !== (k % 2 == 1 ? 4'b0100 : 4'b0001)) begin failures++; $display("FAIL b2b_grant%0d got=%b exp=%b", k, g, (k % 2 == 1 ? 4'b0100 : 4'b0001)); end
      if (k > 0) begin
        checks++; if (36 + gn !== LAT + 3) begin failures++; $display("FAIL b2b_period%0d got=%0d exp=%0d", k, 36 + gn, LAT + 3); end
      end
      @(posedge clk); #1;
      wait_rsp(1, n);
      checks++; if (rsp_id !== 2'(k % 2 * 2) || rsp_data !== 64'd260) begin failures++; $display("FAIL b2b_rsp%0d got=%0d %h exp=%0d 260", k, rsp_id, rsp_data, k % 2 * 2); end
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask
  task automatic test_backpressure();
    logic [N-1:0] g;
    int n, gn;
    do_reset();
    rsp_ready = 1'b0;
    set_op(3, 7, -3);
    req_valid = 4'b1000;
    wait_grant(g, gn);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    wait_rsp(1, n);
    checks++; if (n !== 36) begin failures++; $display("FAIL bp_latency got=%0d exp=36", n); end
    for (int c = 0; c < 10; c++) begin
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFEB}) begin failures++; $display("FAIL bp_hold%0d got=%b %0d %h exp=1 3 ffffffffffffffeb", c, rsp_valid, rsp_id, rsp_data); end
      checks++; if ({req_ready, busy} !== 5'b0000_1) begin failures++; $display("FAIL bp_idle%0d got=%b %b exp=0000 1", c, req_ready, busy); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_no_grant_in_resp got=%b exp=0000", req_ready); end
    @(posedge clk); #1;
    checks++; if ({rsp_valid, req_ready} !== 5'b0_0001) begin failures++; $display("FAIL bp_release got=%b %b exp=0 0001", rsp_valid, req_ready); end
    req_valid = '0;
  endtask
  task automatic test_drop();
    logic [N-1:0] g;
    int n, gn;
    do_reset();
    set_op(0, 2, 3);
    set_op(2, 9, 9);
    set_op(3, 5, 6);
    req_valid = 4'b0001;
    wait_grant(g, gn);
    @(posedge clk); #1;
    req_valid = 4'b1100;
    repeat (5) @(posedge clk);
    #1;
    req_valid = 4'b1000;
    wait_rsp(6, n);
    checks++; if (rsp_data !== 64'd6) begin failures++; $display("FAIL drop_first got=%h exp=6", rsp_data); end
    wait_grant(g, gn);
    checks++; if (g !== 4'b1000) begin failures++; $display("FAIL drop_grant got=%b exp=1000", g); end
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(1, n);
    checks++; if (rsp_id !== 2'd3 || rsp_data !== 64'd30) begin failures++; $display("FAIL drop_rsp got=%0d %h exp=3 30", rsp_id, rsp_data); end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid_run();
    logic [N-1:0] g;
    int n, gn;
    bit seen;
    do_reset();
    set_op(0, 3, 4);
    req_valid = 4'b0001;
    wait_grant(g, gn);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (11) @(posedge clk);
    #1;
    checks++; if (mult_en !== 1'b1) begin failures++; $display("FAIL midrun_running got=%b exp=1", mult_en); end
    rst = 1'b1;
    #1;
    checks++; if ({mult_rst, mult_en, busy, rsp_valid} !== 4'b1000) begin failures++; $display("FAIL midrun_ctl got=%b exp=1000", {mult_rst, mult_en, busy, rsp_valid}); end
    checks++; if ({mult_a, mult_b, rsp_id, rsp_data} !== '0) begin failures++; $display("FAIL midrun_data got=%h %h %0d %h exp=0", mult_a, mult_b, rsp_id, rsp_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrun_discard got=%b exp=0", seen); end
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrun_ptr got=%b exp=0001", req_ready); end
    set_op(1, -12, 72);
    req_valid = 4'b0010;
    wait_grant(g, gn);
    checks++; if (g !== 4'b0010) begin failures++; $display("FAIL midrun_grant1 got=%b exp=0010", g); end
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(1, n);
    checks++; if (n !== 36 || rsp_id !== 2'd1 || rsp_data !== -64'sd864) begin failures++; $display("FAIL midrun_rsp got=%0d %0d %h exp=36 1 %h", n, rsp_id, rsp_data, -64'sd864); end
    @(posedge clk); #1;
  endtask
  task automatic test_extremes();
    logic [N-1:0] g;
    int n, gn;
    do_reset();
    set_op(2, 32'h8000_0000, 32'h8000_0000);
    req_valid = 4'b0100;
    wait_grant(g, gn);
    @(posedge clk); #1;
    set_op(2, 32'h8000_0000, 1);
    wait_rsp(1, n);
    checks++; if (rsp_data !== 64'h4000_0000_0000_0000) begin failures++; $display("FAIL ext_minmin got=%h exp=4000000000000000", rsp_data); end
    wait_grant(g, gn);
    checks++; if (g !== 4'b0100) begin failures++; $display("FAIL ext_grant got=%b exp=0100", g); end
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(1, n);
    checks++; if (rsp_data !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL ext_minone got=%h exp=ffffffff80000000", rsp_data); end
    @(posedge clk); #1;
  endtask
  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_reset_mid_run();
    test_extremes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
